// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client round-robin arbiter for a single strobe/ack memory port
//
// Shares one external memory port between client 0 (instruction-cache refill)
// and client 1 (data-cache refill/write-back). Each client sees the same
// strobe/acknowledge protocol as the memory port itself.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous reset, active-low
//   cN_stb        client N request strobe
//   cN_we         client N write enable (0 = read)
//   cN_addr       client N word address
//   cN_wdata      client N write data
//   cN_rdata      client N read data, valid with cN_ack
//   cN_ack        client N acknowledge, one-cycle pulse
//   memory_stb    memory request strobe (registered)
//   memory_we     memory write enable (registered)
//   memory_addr   memory word address (registered)
//   memory_wdata  memory write data (registered)
//   memory_data   memory read data, valid with memory_ack
//   memory_ack    memory acknowledge, one-cycle pulse

module mem_arbiter #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_stb,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  output logic [DW-1:0] c0_rdata,
  output logic          c0_ack,
  input  logic          c1_stb,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  output logic [DW-1:0] c1_rdata,
  output logic          c1_ack,
  output logic          memory_stb,
  output logic          memory_we,
  output logic [AW-1:0] memory_addr,
  output logic [DW-1:0] memory_wdata,
  input  logic [DW-1:0] memory_data,
  input  logic          memory_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state, state_next;

  // pri: client that wins the next tie (0 or 1)
  logic pri, pri_next;

  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic grant0, grant1;

  // Next-state, grant decision and client-side outputs
  always_comb begin
    state_next = state;
    pri_next   = pri;
    grant0     = 1'b0;
    grant1     = 1'b0;
    c0_ack     = 1'b0;
    c1_ack     = 1'b0;

    case (state)
      IDLE: begin
        // Ties go to the pointer; memory_ack is ignored here
        grant0 = c0_stb && (!c1_stb || !pri);
        grant1 = c1_stb && (!c0_stb ||  pri);
        if (grant0) begin
          state_next = BUSY0;
          pri_next   = 1'b1;
        end else if (grant1) begin
          state_next = BUSY1;
          pri_next   = 1'b0;
        end
      end
      BUSY0: begin
        // Ack goes to the granted client even if it has dropped stb
        c0_ack = memory_ack;
        if (memory_ack) state_next = IDLE;
      end
      BUSY1: begin
        c1_ack = memory_ack;
        if (memory_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data is shared; only the acked client treats it as valid
  assign c0_rdata = memory_data;
  assign c1_rdata = memory_data;

  // State, pointer and latched request fields
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pri     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      pri   <= pri_next;
      // Fields move only on a grant edge, so they stay stable while busy
      if (grant0) begin
        we_q    <= c0_we;
        addr_q  <= c0_addr;
        wdata_q <= c0_wdata;
      end else if (grant1) begin
        we_q    <= c1_we;
        addr_q  <= c1_addr;
        wdata_q <= c1_wdata;
      end
    end
  end

  // memory_stb decodes directly from the state register, so it is glitch-free
  assign memory_stb   = (state == BUSY0) || (state == BUSY1);
  assign memory_we    = we_q;
  assign memory_addr  = addr_q;
  assign memory_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_stb, c0_we, c1_stb, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic          c0_ack, c1_ack;
  logic          memory_stb, memory_we, memory_ack;
  logic [AW-1:0] memory_addr;
  logic [DW-1:0] memory_wdata, memory_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .c0_stb(c0_stb), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_ack(c0_ack),
    .c1_stb(c1_stb), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_ack(c1_ack),
    .memory_stb(memory_stb), .memory_we(memory_we), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_data(memory_data), .memory_ack(memory_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    c0_stb = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    c1_stb = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    memory_ack = 0; memory_data = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    tick(); tick();
    rst = 1;
  endtask

  initial begin
    do_reset();
    settle();
    chk("reset_stb",   {31'd0, memory_stb}, 32'd0);
    chk("reset_we",    {31'd0, memory_we},  32'd0);
    chk("reset_addr",  {18'd0, memory_addr}, 32'd0);
    chk("reset_wdata", memory_wdata, 32'd0);
    chk("reset_acks",  {30'd0, c0_ack, c1_ack}, 32'd0);

    // Simultaneous pair right after reset: c0 first, c1 after one idle cycle
    c0_stb = 1; c0_addr = 14'h0010;
    c1_stb = 1; c1_addr = 14'h0020;
    tick();
    chk("pair1_first_stb",  {31'd0, memory_stb}, 32'd1);
    chk("pair1_first_addr", {18'd0, memory_addr}, 32'h0010);
    memory_ack = 1; memory_data = 32'hAAAA0010; settle();
    chk("pair1_first_acks", {30'd0, c0_ack, c1_ack}, 32'b10);
    chk("pair1_first_rd",   c0_rdata, 32'hAAAA0010);
    tick();
    c0_stb = 0; memory_ack = 0; settle();
    chk("pair1_gap_stb", {31'd0, memory_stb}, 32'd0);
    tick();
    chk("pair1_second_stb",  {31'd0, memory_stb}, 32'd1);
    chk("pair1_second_addr", {18'd0, memory_addr}, 32'h0020);
    memory_ack = 1; settle();
    chk("pair1_second_acks", {30'd0, c0_ack, c1_ack}, 32'b01);
    tick();
    c1_stb = 0; memory_ack = 0;
    tick();

    // Single read from c0: ack 3 cycles after the strobe appears
    c0_stb = 1; c0_we = 0; c0_addr = 14'h0041; settle();
    chk("rd_pre_stb", {31'd0, memory_stb}, 32'd0);
    tick();
    chk("rd_stb",  {31'd0, memory_stb}, 32'd1);
    chk("rd_addr", {18'd0, memory_addr}, 32'h0041);
    chk("rd_we",   {31'd0, memory_we}, 32'd0);
    chk("rd_wait_acks", {30'd0, c0_ack, c1_ack}, 32'b00);
    tick(); tick();
    chk("rd_wait2_addr", {18'd0, memory_addr}, 32'h0041);
    memory_ack = 1; memory_data = 32'hC0F00FCF; settle();
    chk("rd_acks",  {30'd0, c0_ack, c1_ack}, 32'b10);
    chk("rd_rdata", c0_rdata, 32'hC0F00FCF);
    tick();
    c0_stb = 0; memory_ack = 0; settle();
    chk("rd_after_stb",  {31'd0, memory_stb}, 32'd0);
    chk("rd_after_acks", {30'd0, c0_ack, c1_ack}, 32'b00);
    tick();

    // Second simultaneous pair: c0 won last, so c1 goes first
    c0_stb = 1; c0_addr = 14'h0011;
    c1_stb = 1; c1_addr = 14'h0022;
    tick();
    chk("pair2_first_addr", {18'd0, memory_addr}, 32'h0022);
    memory_ack = 1; settle();
    chk("pair2_first_acks", {30'd0, c0_ack, c1_ack}, 32'b01);
    tick();
    c1_stb = 0; memory_ack = 0;
    tick();
    chk("pair2_second_addr", {18'd0, memory_addr}, 32'h0011);
    memory_ack = 1; settle();
    chk("pair2_second_acks", {30'd0, c0_ack, c1_ack}, 32'b10);
    tick();
    c0_stb = 0; memory_ack = 0;
    tick();

    // Write from c1 at the top address, fields held across the busy period
    c1_stb = 1; c1_we = 1; c1_addr = 14'h3FFF; c1_wdata = 32'h12345676;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wr_stb",   {31'd0, memory_stb}, 32'd1);
      chk("wr_we",    {31'd0, memory_we}, 32'd1);
      chk("wr_addr",  {18'd0, memory_addr}, 32'h3FFF);
      chk("wr_wdata", memory_wdata, 32'h12345676);
      chk("wr_noack", {30'd0, c0_ack, c1_ack}, 32'b00);
      tick();
    end
    memory_ack = 1; settle();
    chk("wr_ack", {30'd0, c0_ack, c1_ack}, 32'b01);
    chk("wr_hold_wdata", memory_wdata, 32'h12345676);
    tick();
    c1_stb = 0; c1_we = 0; memory_ack = 0; settle();
    chk("wr_ack_done", {30'd0, c0_ack, c1_ack}, 32'b00);
    chk("wr_stb_done", {31'd0, memory_stb}, 32'd0);
    tick();

    // c0 busy, c1 arrives, c0 re-requests right after its ack: c1 wins
    c0_stb = 1; c0_addr = 14'h0100;
    tick();
    chk("b2b_c0_addr", {18'd0, memory_addr}, 32'h0100);
    c1_stb = 1; c1_addr = 14'h0200;
    tick();
    chk("b2b_busy_addr", {18'd0, memory_addr}, 32'h0100);
    memory_ack = 1; settle();
    chk("b2b_c0_ack", {30'd0, c0_ack, c1_ack}, 32'b10);
    tick();
    c0_addr = 14'h0101; memory_ack = 0; settle();
    chk("b2b_gap_stb", {31'd0, memory_stb}, 32'd0);
    tick();
    chk("b2b_c1_addr", {18'd0, memory_addr}, 32'h0200);
    memory_ack = 1; settle();
    chk("b2b_c1_ack", {30'd0, c0_ack, c1_ack}, 32'b01);
    tick();
    c1_stb = 0; memory_ack = 0;
    tick();
    chk("b2b_c0_again_addr", {18'd0, memory_addr}, 32'h0101);
    memory_ack = 1; settle();
    chk("b2b_c0_again_ack", {30'd0, c0_ack, c1_ack}, 32'b10);
    tick();
    c0_stb = 0; memory_ack = 0;
    tick();

    // Reset during BUSY1 before the ack; a late ack is then ignored
    c1_stb = 1; c1_addr = 14'h0333;
    tick();
    chk("rst_busy_stb", {31'd0, memory_stb}, 32'd1);
    rst = 0; c1_stb = 0;
    tick();
    chk("rst_mid_stb", {31'd0, memory_stb}, 32'd0);
    rst = 1; memory_ack = 1; settle();
    chk("rst_late_acks", {30'd0, c0_ack, c1_ack}, 32'b00);
    tick();
    memory_ack = 0; settle();
    chk("rst_late_stb", {31'd0, memory_stb}, 32'd0);
    tick();

    // Pointer was reset to c0: a tie now goes to c0
    c0_stb = 1; c0_addr = 14'h0007;
    c1_stb = 1; c1_addr = 14'h0008;
    tick();
    chk("rst_pri_addr", {18'd0, memory_addr}, 32'h0007);
    memory_ack = 1; tick();
    c0_stb = 0; memory_ack = 0;
    tick();
    memory_ack = 1; tick();
    c1_stb = 0; memory_ack = 0;
    tick();

    // Spurious ack in IDLE
    memory_ack = 1; settle();
    chk("spur_acks", {30'd0, c0_ack, c1_ack}, 32'b00);
    tick();
    memory_ack = 0; settle();
    chk("spur_stb", {31'd0, memory_stb}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
